// File: rtl/diff_rx_pkg.sv
// Shared definitions for the differential receiver: pair encodings,
// saturating counter helper and parameter legality check.
package diff_rx_pkg;

  localparam logic [1:0] PAIR_ONE  = 2'b10;
  localparam logic [1:0] PAIR_ZERO = 2'b01;

  // Widest error counter the helper below supports.
  localparam int MAX_ERR_W = 32;

  function automatic logic [MAX_ERR_W-1:0] sat_inc(
    input logic [MAX_ERR_W-1:0] val,
    input logic [MAX_ERR_W-1:0] max_val
  );
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

  function automatic bit params_ok(
    input int channels,
    input int sync_stages,
    input int filter_len,
    input int err_w
  );
    return (channels    >= 1) && (channels    <= 32) &&
           (sync_stages >= 2) && (sync_stages <= 4)  &&
           (filter_len  >= 1) && (filter_len  <= 16) &&
           (err_w       >= 1) && (err_w       <= MAX_ERR_W);
  endfunction

endpackage

// File: rtl/diff_rx_chan.sv
// One receiver channel: pair synchroniser, decode, consecutive-sample
// glitch filter with hold-on-invalid, edge flags and error counter.
module diff_rx_chan
  import diff_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int ERR_W       = 8,
  parameter bit INIT_VAL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_p,
  input  logic             din_n,
  input  logic             err_clr,
  output logic             dout,
  output logic             pair_ok,
  output logic             rise,
  output logic             fall,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] err_next
);

  localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  // Run value at which the next matching sample completes the streak.
  localparam logic [RUN_W-1:0] RUN_FIRE = RUN_W'((FILTER_LEN > 1) ? FILTER_LEN - 2 : 0);
  localparam logic [MAX_ERR_W-1:0] ERR_MAX = MAX_ERR_W'((64'd1 << ERR_W) - 64'd1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic [SYNC_STAGES-1:0] sync_n;
  logic                   valid;
  logic                   sample;
  logic                   cand;
  logic [RUN_W-1:0]       run;

  // Each leg is synchronised on its own; both legs share the same depth so
  // the final-stage pair stays time-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
      sync_n <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain shifts one stage per clock.
      sync_p <= {sync_p[SYNC_STAGES-2:0], din_p};
      sync_n <= {sync_n[SYNC_STAGES-2:0], din_n};
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    valid  = 1'b0;
    sample = 1'b0;
    case ({sync_p[SYNC_STAGES-1], sync_n[SYNC_STAGES-1]})
      PAIR_ONE:  begin valid = 1'b1; sample = 1'b1; end
      PAIR_ZERO: begin valid = 1'b1; sample = 1'b0; end
      default:   ;
    endcase
  end

  // Clear wins over an increment arriving on the same edge.
  always_comb begin
    err_next = err_cnt;
    if (err_clr)
      err_next = '0;
    else if (!valid)
      err_next = ERR_W'(sat_inc(MAX_ERR_W'(err_cnt), ERR_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= INIT_VAL;
      cand    <= INIT_VAL;
      run     <= '0;
      pair_ok <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      err_cnt <= '0;
    end else begin
      pair_ok <= valid;
      rise    <= 1'b0;
      fall    <= 1'b0;
      err_cnt <= err_next;
      if (!valid || sample == dout) begin
        run  <= '0;
        cand <= dout;
      end else if (FILTER_LEN == 1 || (sample == cand && run == RUN_FIRE)) begin
        dout <= sample;
        cand <= sample;
        run  <= '0;
        rise <= sample;
        fall <= ~sample;
      end else if (sample == cand) begin
        run <= run + RUN_W'(1);
      end else begin
        cand <= sample;
        run  <= '0;
      end
    end
  end

endmodule

// File: rtl/diff_rx_filter.sv
// Multi-channel differential receiver: replicates diff_rx_chan per pair,
// packs the counters and registers the any-error summary.
module diff_rx_filter
  import diff_rx_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int ERR_W       = 8,
  parameter bit INIT_VAL    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       din_p,
  input  logic [CHANNELS-1:0]       din_n,
  input  logic                      err_clr,
  output logic [CHANNELS-1:0]       dout,
  output logic [CHANNELS-1:0]       pair_ok,
  output logic [CHANNELS-1:0]       rise,
  output logic [CHANNELS-1:0]       fall,
  output logic [CHANNELS*ERR_W-1:0] err_cnt,
  output logic                      any_err
);

  logic [CHANNELS*ERR_W-1:0] err_next;

  if (!params_ok(CHANNELS, SYNC_STAGES, FILTER_LEN, ERR_W)) begin : g_param_check
    $error("diff_rx_filter: parameter out of range");
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    diff_rx_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .ERR_W       (ERR_W),
      .INIT_VAL    (INIT_VAL)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .din_p    (din_p[k]),
      .din_n    (din_n[k]),
      .err_clr  (err_clr),
      .dout     (dout[k]),
      .pair_ok  (pair_ok[k]),
      .rise     (rise[k]),
      .fall     (fall[k]),
      .err_cnt  (err_cnt[k*ERR_W +: ERR_W]),
      .err_next (err_next[k*ERR_W +: ERR_W])
    );
  end

  // Built from next-state counters so it drops together with err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_err <= 1'b0;
    else        any_err <= |err_next;
  end

endmodule

// File: tb/tb_diff_rx_filter.sv
// Bench for diff_rx_filter: cycle scoreboard against a streak-based model,
// a settled-vector table and hand sequences for latency/glitch/error cases.
module tb_diff_rx_filter;

  localparam int CH   = 4;
  localparam int SS   = 2;
  localparam int FL   = 3;
  localparam int EW   = 4;
  localparam bit INIT = 1'b0;
  localparam logic [EW-1:0] EMAX = '1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH-1:0]    din_p;
  logic [CH-1:0]    din_n;
  logic             err_clr;
  logic [CH-1:0]    dout;
  logic [CH-1:0]    pair_ok;
  logic [CH-1:0]    rise;
  logic [CH-1:0]    fall;
  logic [CH*EW-1:0] err_cnt;
  logic             any_err;

  diff_rx_filter #(
    .CHANNELS    (CH),
    .SYNC_STAGES (SS),
    .FILTER_LEN  (FL),
    .ERR_W       (EW),
    .INIT_VAL    (INIT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_p   (din_p),
    .din_n   (din_n),
    .err_clr (err_clr),
    .dout    (dout),
    .pair_ok (pair_ok),
    .rise    (rise),
    .fall    (fall),
    .err_cnt (err_cnt),
    .any_err (any_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]    dout;
    logic [CH-1:0]    ok;
    logic [CH-1:0]    rise;
    logic [CH-1:0]    fall;
    logic [CH*EW-1:0] err;
    logic             any;
  } obs_t;

  typedef struct {
    logic [CH-1:0] p;
    logic [CH-1:0] n;
    logic [CH-1:0] exp_dout;
    logic [CH-1:0] exp_ok;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  obs_t sb[$];

  // Reference model: streak of consecutive valid samples that differ from dout.
  logic [SS-1:0] m_sp [CH];
  logic [SS-1:0] m_sn [CH];
  logic [EW-1:0] m_err [CH];
  int            m_streak [CH];
  logic [CH-1:0] m_dout, m_ok, m_rise, m_fall;
  logic          m_any;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_sp[k] = '0; m_sn[k] = '0; m_err[k] = '0; m_streak[k] = 0;
    end
    m_dout = {CH{INIT}}; m_ok = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
  endtask

  task automatic model_step();
    logic sp, sn, ok;
    m_any = 1'b0;
    for (int k = 0; k < CH; k++) begin
      sp = m_sp[k][SS-1];
      sn = m_sn[k][SS-1];
      ok = (sp != sn);
      m_ok[k] = ok; m_rise[k] = 1'b0; m_fall[k] = 1'b0;
      if (err_clr) m_err[k] = '0;
      else if (!ok && m_err[k] != EMAX) m_err[k] = m_err[k] + 1'b1;
      if (!ok || sp == m_dout[k]) m_streak[k] = 0;
      else begin
        m_streak[k]++;
        if (m_streak[k] == FL) begin
          m_dout[k] = sp; m_rise[k] = sp; m_fall[k] = ~sp; m_streak[k] = 0;
        end
      end
      m_sp[k] = {m_sp[k][SS-2:0], din_p[k]};
      m_sn[k] = {m_sn[k][SS-2:0], din_n[k]};
      if (m_err[k] != '0) m_any = 1'b1;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.dout = m_dout; o.ok = m_ok; o.rise = m_rise; o.fall = m_fall; o.any = m_any;
    for (int k = 0; k < CH; k++) o.err[k*EW +: EW] = m_err[k];
    return o;
  endfunction

  // One clock: model advances on the edge, DUT is compared on the falling edge.
  task automatic tick();
    obs_t e, a;
    @(posedge clk);
    if (rst_n) model_step();
    sb.push_back(model_obs());
    @(negedge clk);
    cyc++;
    e = sb.pop_front();
    a.dout = dout; a.ok = pair_ok; a.rise = rise; a.fall = fall; a.err = err_cnt; a.any = any_err;
    check($sformatf("scoreboard_cycle%0d", cyc), 64'(a), 64'(e));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ch(input int k, input logic p, input logic n);
    din_p[k] = p;
    din_n[k] = n;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [6];
    int   lat, low_cnt, drop, seen_r, seen_f;
    int   first [CH];

    vecs[0] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
    vecs[1] = '{4'b1111, 4'b0000, 4'b1111, 4'b1111};
    vecs[2] = '{4'b0101, 4'b1010, 4'b0101, 4'b1111};
    vecs[3] = '{4'b0011, 4'b1111, 4'b0001, 4'b1100};
    vecs[4] = '{4'b1010, 4'b0101, 4'b1010, 4'b1111};
    vecs[5] = '{4'b0000, 4'b0000, 4'b1010, 4'b0000};

    // Reset state.
    rst_n = 1'b0; din_p = '0; din_n = '1; err_clr = 1'b0;
    model_reset();
    #2;
    check("reset_dout", 64'(dout), 64'({CH{INIT}}));
    check("reset_err_cnt", 64'(err_cnt), 64'd0);
    check("reset_pair_ok", 64'(pair_ok), 64'd0);
    check("reset_rise_fall", 64'({rise, fall}), 64'd0);
    check("reset_any_err", 64'(any_err), 64'd0);
    run(2);
    rst_n = 1'b1;
    run(6);
    clear_errors();
    check("clear_err_cnt", 64'(err_cnt), 64'd0);
    check("clear_any_err", 64'(any_err), 64'd0);

    // Settled vectors.
    for (int v = 0; v < 6; v++) begin
      din_p = vecs[v].p;
      din_n = vecs[v].n;
      run(6);
      check($sformatf("vec%0d_dout", v), 64'(dout), 64'(vecs[v].exp_dout));
      check($sformatf("vec%0d_pair_ok", v), 64'(pair_ok), 64'(vecs[v].exp_ok));
    end

    // Reset after 2 of 3 filter samples discards the partial count.
    din_p = 4'b0000; din_n = 4'b1111;
    run(6);
    clear_errors();
    set_ch(0, 1'b1, 1'b0);
    run(4);
    check("midreset_before", 64'(dout[0]), 64'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_during", 64'(dout[0]), 64'd0);
    run(1);
    rst_n = 1'b1;
    run(4);
    check("midreset_restart_hold", 64'(dout[0]), 64'd0);
    run(1);
    check("midreset_restart_rise", 64'(dout[0]), 64'd1);
    clear_errors();

    // Latency of a clean 0->1 step on ch0.
    set_ch(0, 1'b0, 1'b1);
    run(6);
    set_ch(0, 1'b1, 1'b0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dout[0]) begin lat = i; break; end
    end
    check("latency_ch0", 64'(lat), 64'd5);
    check("rise_ch0_pulse", 64'(rise[0]), 64'd1);
    check("fall_ch0_quiet", 64'(fall[0]), 64'd0);
    tick();
    check("rise_ch0_one_cycle", 64'(rise[0]), 64'd0);

    // Two-sample glitch on ch2 is rejected; a three-sample one passes.
    seen_r = 0;
    set_ch(2, 1'b1, 1'b0);
    run(2);
    set_ch(2, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rise[2] || dout[2]) seen_r = 1;
    end
    check("glitch2_no_toggle", 64'(seen_r), 64'd0);
    seen_r = 0; seen_f = 0;
    set_ch(2, 1'b1, 1'b0);
    run(3);
    set_ch(2, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rise[2]) seen_r = 1;
      if (fall[2]) seen_f = 1;
    end
    check("glitch3_rise", 64'(seen_r), 64'd1);
    check("glitch3_fall_back", 64'(seen_f), 64'd1);

    // Invalid (1,1) on ch1 for 4 cycles while dout[1]=1.
    set_ch(1, 1'b1, 1'b0);
    run(6);
    clear_errors();
    set_ch(1, 1'b1, 1'b1);
    low_cnt = 0; drop = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) set_ch(1, 1'b1, 1'b0);
      tick();
      if (!pair_ok[1]) low_cnt++;
      if (!dout[1]) drop = 1;
    end
    check("invalid_pair_ok_low_cycles", 64'(low_cnt), 64'd4);
    check("invalid_dout_held", 64'(drop), 64'd0);
    check("invalid_err_cnt_ch1", 64'(err_cnt[1*EW +: EW]), 64'd4);
    check("invalid_any_err", 64'(any_err), 64'd1);

    // Saturation on ch3, then clear with a coincident invalid sample.
    set_ch(3, 1'b0, 1'b0);
    run(20);
    check("saturate_ch3", 64'(err_cnt[3*EW +: EW]), 64'd15);
    clear_errors();
    check("clear_priority_ch3", 64'(err_cnt[3*EW +: EW]), 64'd0);
    check("clear_priority_any_err", 64'(any_err), 64'd0);
    set_ch(3, 1'b0, 1'b1);
    run(4);

    // Staggered toggles: each channel keeps its own latency.
    din_p = 4'b0000; din_n = 4'b1111;
    run(6);
    clear_errors();
    for (int k = 0; k < CH; k++) first[k] = -1;
    for (int t = 0; t < 16; t++) begin
      for (int k = 0; k < CH; k++) if (t == 2 * k) set_ch(k, 1'b1, 1'b0);
      tick();
      for (int k = 0; k < CH; k++) if (dout[k] && first[k] < 0) first[k] = t;
    end
    for (int k = 0; k < CH; k++)
      check($sformatf("stagger_ch%0d_edge", k), 64'(first[k]), 64'(2 * k + 4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
